// File: rtl/inst_mem_fetch.sv
// Loadable instruction memory. A clear sweep runs after reset, then the block serves registered valid/ready fetches.
// Optional per-word even parity is enabled by defining INST_MEM_PARITY_EN.
module inst_mem_fetch #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic [31:0]           Addr,
  output logic                  RespValid,
  input  logic                  RespReady,
  output logic [DATA_WIDTH-1:0] Inst,
  output logic                  AddrErr,
  output logic                  ParityErr,
  input  logic                  LoadEn,
  input  logic [DEPTH_LOG2-1:0] LoadAddr,
  input  logic [DATA_WIDTH-1:0] LoadData,
  output logic                  Busy
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] clr_ptr_q, clr_ptr_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic                  addr_err_q, addr_err_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic                  accept;
  logic                  borrow;
  logic [29:0]           off_hi;
  logic                  err;
  logic [DEPTH_LOG2-1:0] idx;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    mem_we    = 1'b0;
    mem_waddr = LoadAddr;
    mem_wdata = LoadData;
    unique case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + DEPTH_LOG2'(1);
        if (clr_ptr_q == '1) state_d = S_READY;
      end
      S_READY: mem_we = LoadEn;
      default: state_d = S_CLEAR;
    endcase
  end

  assign Busy     = (state_q == S_CLEAR);
  assign ReqReady = (state_q == S_READY) && !LoadEn && (!resp_valid_q || RespReady);
  assign accept   = ReqValid && ReqReady;

  // Bits [31:2] of (Addr - BASE_ADDR) formed directly, with the borrow out of the low two bits.
  assign borrow = (Addr[1:0] < BASE_ADDR[1:0]);
  assign off_hi = Addr[31:2] - BASE_ADDR[31:2] - {29'd0, borrow};
  assign err    = (Addr[1:0] != 2'b00) || (off_hi[29:DEPTH_LOG2] != '0);
  assign idx    = off_hi[DEPTH_LOG2-1:0];

  always_comb begin
    resp_valid_d = resp_valid_q;
    inst_d       = inst_q;
    addr_err_d   = addr_err_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      inst_d       = err ? '0 : mem_q[idx];
      addr_err_d   = err;
    end else if (RespReady) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_CLEAR;
      clr_ptr_q    <= '0;
      resp_valid_q <= 1'b0;
      inst_q       <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      resp_valid_q <= resp_valid_d;
      inst_q       <= inst_d;
      addr_err_q   <= addr_err_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign RespValid = resp_valid_q;
  assign Inst      = inst_q;
  assign AddrErr   = addr_err_q;

`ifdef INST_MEM_PARITY_EN
  logic mem_par_q [DEPTH];
  logic par_err_q, par_err_d;

  always_ff @(posedge Clk) begin
    if (mem_we) mem_par_q[mem_waddr] <= ^mem_wdata;
  end

  always_comb begin
    par_err_d = par_err_q;
    if (accept) par_err_d = err ? 1'b0 : ((^mem_q[idx]) ^ mem_par_q[idx]);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) par_err_q <= 1'b0;
    else       par_err_q <= par_err_d;
  end

  assign ParityErr = par_err_q;
`else
  assign ParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_inst_mem_fetch.sv
// Directed self-checking bench for inst_mem_fetch with default parameters (DEPTH = 256, BASE_ADDR = 0).
module tb_inst_mem_fetch;

  localparam int unsigned DEPTH = 256;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic [31:0] Addr;
  logic        RespValid;
  logic        RespReady;
  logic [31:0] Inst;
  logic        AddrErr;
  logic        ParityErr;
  logic        LoadEn;
  logic [7:0]  LoadAddr;
  logic [31:0] LoadData;
  logic        Busy;

  int total = 0;
  int bad   = 0;

  inst_mem_fetch #(
    .DATA_WIDTH(32),
    .DEPTH_LOG2(8),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ReqValid (ReqValid),
    .ReqReady (ReqReady),
    .Addr     (Addr),
    .RespValid(RespValid),
    .RespReady(RespReady),
    .Inst     (Inst),
    .AddrErr  (AddrErr),
    .ParityErr(ParityErr),
    .LoadEn   (LoadEn),
    .LoadAddr (LoadAddr),
    .LoadData (LoadData),
    .Busy     (Busy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] a, input logic [31:0] d);
    LoadEn = 1'b1; LoadAddr = a; LoadData = d;
    tick();
    LoadEn = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    int rr_bad;
    Reset = 1'b1; ReqValid = 1'b0; Addr = '0; RespReady = 1'b1;
    LoadEn = 1'b0; LoadAddr = '0; LoadData = '0;
    tick(); tick();
    total++; if (RespValid !== 1'b0) begin bad++; $display("FAIL rst_respvalid got=%b exp=0", RespValid); end
    total++; if (Inst !== 32'h0) begin bad++; $display("FAIL rst_inst got=%h exp=00000000", Inst); end
    total++; if (AddrErr !== 1'b0 || ParityErr !== 1'b0) begin bad++; $display("FAIL rst_errs got=%b%b exp=00", AddrErr, ParityErr); end
    total++; if (ReqReady !== 1'b0 || Busy !== 1'b1) begin bad++; $display("FAIL rst_rdy_busy got=%b%b exp=01", ReqReady, Busy); end
    Reset = 1'b0;
    ReqValid = 1'b1; Addr = 32'h4;
    n = 0; rr_bad = 0;
    while (Busy === 1'b1 && n < 4 * DEPTH) begin
      if (ReqReady !== 1'b0) rr_bad++;
      tick();
      n++;
    end
    total++; if (n != DEPTH) begin bad++; $display("FAIL busy_len got=%0d exp=%0d", n, DEPTH); end
    total++; if (rr_bad != 0) begin bad++; $display("FAIL ready_during_clear got=%0d exp=0", rr_bad); end
    total++; if (ReqReady !== 1'b1) begin bad++; $display("FAIL first_ready got=%b exp=1", ReqReady); end
    tick();
    total++; if (RespValid !== 1'b1 || Inst !== 32'h0 || AddrErr !== 1'b0) begin
      bad++; $display("FAIL first_fetch got=v%b i=%h e=%b exp=v1 i=00000000 e=0", RespValid, Inst, AddrErr); end
    ReqValid = 1'b0;
    tick();
    total++; if (RespValid !== 1'b0) begin bad++; $display("FAIL resp_drain got=%b exp=0", RespValid); end
  endtask

  task automatic test_back_to_back();
    load_word(8'd1, 32'h8C1F0000);
    load_word(8'd2, 32'h001FF022);
    ReqValid = 1'b1; Addr = 32'h4; RespReady = 1'b1;
    tick();
    total++; if (RespValid !== 1'b1 || Inst !== 32'h8C1F0000) begin
      bad++; $display("FAIL b2b_first got=v%b i=%h exp=v1 i=8c1f0000", RespValid, Inst); end
    Addr = 32'h8;
    tick();
    total++; if (RespValid !== 1'b1 || Inst !== 32'h001FF022 || AddrErr !== 1'b0) begin
      bad++; $display("FAIL b2b_second got=v%b i=%h e=%b exp=v1 i=001ff022 e=0", RespValid, Inst, AddrErr); end
    ReqValid = 1'b0;
    tick();
    total++; if (RespValid !== 1'b0 || Inst !== 32'h001FF022) begin
      bad++; $display("FAIL b2b_hold got=v%b i=%h exp=v0 i=001ff022", RespValid, Inst); end
  endtask

  task automatic test_backpressure();
    ReqValid = 1'b1; Addr = 32'h4; RespReady = 1'b0;
    tick();
    Addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      total++; if (RespValid !== 1'b1 || Inst !== 32'h8C1F0000 || ReqReady !== 1'b0) begin
        bad++; $display("FAIL stall_%0d got=v%b i=%h r=%b exp=v1 i=8c1f0000 r=0", i, RespValid, Inst, ReqReady); end
      tick();
    end
    RespReady = 1'b1;
    #1;
    total++; if (ReqReady !== 1'b1) begin bad++; $display("FAIL stall_release got=%b exp=1", ReqReady); end
    tick();
    total++; if (RespValid !== 1'b1 || Inst !== 32'h001FF022) begin
      bad++; $display("FAIL stall_next got=v%b i=%h exp=v1 i=001ff022", RespValid, Inst); end
    ReqValid = 1'b0;
    tick();
  endtask

  task automatic test_addr_err();
    logic [31:0] addrs [3];
    addrs[0] = 32'h0000_0006;
    addrs[1] = DEPTH * 4;
    addrs[2] = 32'hFFFF_FFFC;
    load_word(8'd0, 32'hDEADBEEF);
    RespReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ReqValid = 1'b1; Addr = addrs[i];
      tick();
      total++; if (RespValid !== 1'b1 || Inst !== 32'h0 || AddrErr !== 1'b1 || ParityErr !== 1'b0) begin
        bad++; $display("FAIL addr_err a=%h got=v%b i=%h e=%b p=%b exp=v1 i=00000000 e=1 p=0",
                        addrs[i], RespValid, Inst, AddrErr, ParityErr); end
    end
    Addr = 32'h0;
    tick();
    total++; if (Inst !== 32'hDEADBEEF || AddrErr !== 1'b0) begin
      bad++; $display("FAIL err_recover got=i=%h e=%b exp=i=deadbeef e=0", Inst, AddrErr); end
    ReqValid = 1'b0;
    tick();
  endtask

  task automatic test_load_priority();
    LoadEn = 1'b1; LoadAddr = 8'd3; LoadData = 32'h12345678;
    ReqValid = 1'b1; Addr = 32'hC; RespReady = 1'b1;
    #1;
    total++; if (ReqReady !== 1'b0) begin bad++; $display("FAIL load_prio_ready got=%b exp=0", ReqReady); end
    tick();
    LoadEn = 1'b0;
    total++; if (RespValid !== 1'b0) begin bad++; $display("FAIL load_prio_noaccept got=%b exp=0", RespValid); end
    tick();
    total++; if (RespValid !== 1'b1 || Inst !== 32'h12345678 || ParityErr !== 1'b0) begin
      bad++; $display("FAIL load_then_fetch got=v%b i=%h p=%b exp=v1 i=12345678 p=0", RespValid, Inst, ParityErr); end
    ReqValid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    load_word(8'd5, 32'hCAFEF00D);
    ReqValid = 1'b1; Addr = 32'h14; RespReady = 1'b0;
    tick();
    ReqValid = 1'b0;
    total++; if (RespValid !== 1'b1 || Inst !== 32'hCAFEF00D) begin
      bad++; $display("FAIL pre_reset_fetch got=v%b i=%h exp=v1 i=cafef00d", RespValid, Inst); end
    Reset = 1'b1;
    #1;
    total++; if (RespValid !== 1'b0 || Inst !== 32'h0 || Busy !== 1'b1) begin
      bad++; $display("FAIL async_reset got=v%b i=%h b=%b exp=v0 i=00000000 b=1", RespValid, Inst, Busy); end
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    ReqValid = 1'b1; RespReady = 1'b1;
    n = 0;
    while (ReqReady !== 1'b1 && n < 4 * DEPTH) begin
      tick();
      n++;
    end
    total++; if (n != DEPTH) begin bad++; $display("FAIL restart_len got=%0d exp=%0d", n, DEPTH); end
    tick();
    total++; if (RespValid !== 1'b1 || Inst !== 32'h0 || AddrErr !== 1'b0) begin
      bad++; $display("FAIL cleared_word got=v%b i=%h e=%b exp=v1 i=00000000 e=0", RespValid, Inst, AddrErr); end
    ReqValid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_addr_err();
    test_load_priority();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
